clk_en_gen: RTL and testbench

CLK_EN_GEN -- requirements
Module: clk_en_gen

---
 rtl/clk_en_gen.sv | 134 +++++++++++++
 tb/tb_clk_en_gen.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_en_gen.sv
// Multi-channel clock-enable generator gated by a synchronised MMCM lock.
// Optional build macro CLK_EN_SYNC_EN adds sync_in for a run-time phase realign.
module clk_en_gen #(
  parameter  int CHANNELS    = 4,
  parameter  int CNT_W       = 8,
  parameter  int DEFAULT_DIV = 6,
  parameter  int LOCK_CYCLES = 16,
  localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                aclk,
  input  logic                rst,
  input  logic                lock_in,
  input  logic                div_wr,
  input  logic [CH_W-1:0]     div_ch,
  input  logic [CNT_W-1:0]    div_val,
  input  logic                lost_clr,
`ifdef CLK_EN_SYNC_EN
  input  logic                sync_in,
`endif
  output logic [CHANNELS-1:0] ce,
  output logic                rstn_out,
  output logic                locked,
  output logic                lock_lost
);

  localparam int SET_W       = $clog2(LOCK_CYCLES + 1);
  // The UNLOCKED cycle that first sees lk=1 counts as the first lock cycle.
  localparam int SETTLE_LAST = (LOCK_CYCLES > 1) ? LOCK_CYCLES - 2 : 0;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    SETTLE   = 2'd1,
    RUN      = 2'd2
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic                lk_meta;
  logic                lk;
  logic [SET_W-1:0]    settle_cnt;
  logic                run_q;
  logic                lost_q;
  logic                in_run;
  logic                realign;
  logic [CNT_W-1:0]    act_q  [CHANNELS];
  logic [CNT_W-1:0]    pend_q [CHANNELS];
  logic [CNT_W-1:0]    cnt_q  [CHANNELS];
  logic [CHANNELS-1:0] wrap;

  always_ff @(posedge aclk) begin
    if (rst) begin
      lk_meta <= 1'b0;
      lk      <= 1'b0;
    end else begin
      lk_meta <= lock_in;
      lk      <= lk_meta;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      UNLOCKED: if (lk) state_d = SETTLE;
      SETTLE: begin
        if (!lk)                                     state_d = UNLOCKED;
        else if (settle_cnt == SET_W'(SETTLE_LAST)) state_d = RUN;
      end
      RUN:      if (!lk) state_d = UNLOCKED;
      default:  state_d = UNLOCKED;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      state_q    <= UNLOCKED;
      settle_cnt <= '0;
      run_q      <= 1'b0;
      lost_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      settle_cnt <= (state_q == SETTLE) ? settle_cnt + SET_W'(1) : '0;
      run_q      <= (state_d == RUN);
      if (state_q == RUN && state_d == UNLOCKED) lost_q <= 1'b1;
      else if (lost_clr)                         lost_q <= 1'b0;
    end
  end

  assign in_run    = (state_q == RUN);
  assign locked    = run_q;
  assign rstn_out  = run_q;
  assign lock_lost = lost_q;

`ifdef CLK_EN_SYNC_EN
  assign realign = in_run && sync_in;
`else
  assign realign = 1'b0;
`endif

  always_comb begin
    wrap = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      wrap[i] = (act_q[i] <= CNT_W'(1)) || (cnt_q[i] == act_q[i] - CNT_W'(1));
    end
  end

  assign ce = in_run ? wrap : '0;

  // Pending ratio is promoted only at a wrap (or realign), when the counter
  // restarts from 0, so a period is never cut short or stretched.
  always_ff @(posedge aclk) begin
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (rst) begin
        cnt_q[i]  <= '0;
        act_q[i]  <= CNT_W'(DEFAULT_DIV);
        pend_q[i] <= CNT_W'(DEFAULT_DIV);
      end else if (in_run) begin
        if (wrap[i] || realign) begin
          act_q[i] <= pend_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
        if (div_wr && div_ch == CH_W'(i)) pend_q[i] <= div_val;
      end else begin
        cnt_q[i] <= '0;
        if (div_wr && div_ch == CH_W'(i)) begin
          act_q[i]  <= div_val;
          pend_q[i] <= div_val;
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_en_gen.sv
// Self-checking bench for clk_en_gen against a timestamp-based reference model.
// Define CLK_EN_SYNC_EN for both files to exercise the sync_in realign.
module tb_clk_en_gen;

  logic       aclk = 1'b0;
  logic       rst, lock_in, div_wr, lost_clr, div_wr_b;
  logic [1:0] div_ch, div_ch_b;
  logic [7:0] div_val;
  logic [3:0] ce;
  logic [2:0] ce_b;
  logic       rstn_out, locked, lock_lost, rstn_b, locked_b, lost_b;
`ifdef CLK_EN_SYNC_EN
  logic       sync_in;
`endif

  always #5 aclk = ~aclk;

  clk_en_gen #(.CHANNELS(4), .CNT_W(8), .DEFAULT_DIV(6), .LOCK_CYCLES(16)) dut (
    .aclk(aclk), .rst(rst), .lock_in(lock_in), .div_wr(div_wr), .div_ch(div_ch),
    .div_val(div_val), .lost_clr(lost_clr),
`ifdef CLK_EN_SYNC_EN
    .sync_in(sync_in),
`endif
    .ce(ce), .rstn_out(rstn_out), .locked(locked), .lock_lost(lock_lost));

  // Three channels on a 2-bit div_ch, so index 3 is out of range.
  clk_en_gen #(.CHANNELS(3), .CNT_W(8), .DEFAULT_DIV(6), .LOCK_CYCLES(16)) dut_b (
    .aclk(aclk), .rst(rst), .lock_in(lock_in), .div_wr(div_wr_b), .div_ch(div_ch_b),
    .div_val(div_val), .lost_clr(lost_clr),
`ifdef CLK_EN_SYNC_EN
    .sync_in(1'b0),
`endif
    .ce(ce_b), .rstn_out(rstn_b), .locked(locked_b), .lock_lost(lost_b));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: lock history, streak of synchronised-high samples, and
  // per-channel period start timestamps.
  int cyc = 0;
  bit h1, h2, m_run, m_lost;
  int streak, run_start;
  int n_act[4], n_pend[4], pstart[4];

  function automatic logic [3:0] exp_ce();
    logic [3:0] r;
    for (int i = 0; i < 4; i++)
      r[i] = m_run && ((n_act[i] <= 1) || (cyc - pstart[i] == n_act[i] - 1));
    return r;
  endfunction

  function automatic logic [2:0] exp_ce_b();
    return {3{m_run && ((cyc - run_start) % 6 == 5)}};
  endfunction

  function automatic logic [12:0] obs_vec();
    return {ce, locked, rstn_out, lock_lost, ce_b, locked_b, rstn_b, lost_b};
  endfunction

  function automatic logic [12:0] exp_vec();
    return {exp_ce(), m_run, m_run, m_lost, exp_ce_b(), m_run, m_run, m_lost};
  endfunction

  task automatic model_step();
    bit lk, was_run, nr, wr, sn;
    int oc;
    oc = cyc;
    cyc = cyc + 1;
    sn = 1'b0;
`ifdef CLK_EN_SYNC_EN
    sn = sync_in;
`endif
    if (rst) begin
      h1 = 0; h2 = 0; streak = 0; m_run = 0; m_lost = 0;
      for (int i = 0; i < 4; i++) begin
        n_act[i] = 6; n_pend[i] = 6; pstart[i] = cyc;
      end
    end else begin
      lk = h2; h2 = h1; h1 = lock_in;
      was_run = m_run;
      for (int i = 0; i < 4; i++) begin
        wr = div_wr && (int'(div_ch) == i);
        if (was_run) begin
          if ((n_act[i] <= 1) || (oc - pstart[i] == n_act[i] - 1) || sn) begin
            n_act[i] = n_pend[i];
            pstart[i] = cyc;
          end
          if (wr) n_pend[i] = int'(div_val);
        end else if (wr) begin
          n_act[i] = int'(div_val);
          n_pend[i] = int'(div_val);
        end
      end
      streak = lk ? streak + 1 : 0;
      nr = lk && (streak >= 16);
      if (!was_run && nr) begin
        run_start = cyc;
        for (int i = 0; i < 4; i++) pstart[i] = cyc;
      end
      if (was_run && !nr) m_lost = 1;
      else if (lost_clr)  m_lost = 0;
      m_run = nr;
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    model_step();
    @(negedge aclk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_tests++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL reset_vec got=%b exp=%b", obs_vec(), exp_vec());
    end
    n_tests++;
    if ({ce, rstn_out, locked, lock_lost} !== 7'b0) begin
      n_fail++; $display("FAIL reset_outputs got=%b exp=0000000", {ce, rstn_out, locked, lock_lost});
    end
    rst = 1'b0;
  endtask

  task automatic test_lock();
    int t0, rise, first_ce, npulse;
    lock_in = 1'b1;
    t0 = cyc;
    rise = -1;
    for (int k = 0; k < 40 && rise < 0; k++) begin
      tick();
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL lock_vec cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec());
      end
      if (locked === 1'b1) rise = cyc - t0;
    end
    n_tests++;
    if (rise != 18) begin
      n_fail++; $display("FAIL lock_rise got=%0d exp=18", rise);
    end
    first_ce = -1;
    npulse = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL run_vec cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec());
      end
      if (first_ce < 0 && ce === 4'hf) first_ce = cyc - (t0 + 18);
      if (ce[0] === 1'b1) npulse++;
    end
    n_tests++;
    if (first_ce != 5) begin
      n_fail++; $display("FAIL first_ce got=%0d exp=5", first_ce);
    end
    n_tests++;
    if (npulse != 5) begin
      n_fail++; $display("FAIL ce0_pulses got=%0d exp=5", npulse);
    end
  endtask

  task automatic test_reset_mid_run();
    rst = 1'b1;
    tick();
    n_tests++;
    if ({locked, rstn_out, ce, lock_lost} !== 7'b0) begin
      n_fail++; $display("FAIL midrun_reset got=%b exp=0000000", {locked, rstn_out, ce, lock_lost});
    end
    rst = 1'b0;
    lock_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL midrun_vec cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_settle_abort();
    int highs, t0, rise;
    highs = 0;
    lock_in = 1'b1;
    for (int k = 0; k < 15; k++) begin
      if (k == 10) lock_in = 1'b0;
      tick();
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL abort_vec cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec());
      end
      if (locked !== 1'b0) highs++;
    end
    n_tests++;
    if (highs != 0) begin
      n_fail++; $display("FAIL abort_locked got=%0d exp=0", highs);
    end
    lock_in = 1'b1;
    t0 = cyc;
    rise = -1;
    for (int k = 0; k < 40 && rise < 0; k++) begin
      tick();
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL relock_vec cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec());
      end
      if (locked === 1'b1) rise = cyc - t0;
    end
    n_tests++;
    if (rise != 18) begin
      n_fail++; $display("FAIL relock_rise got=%0d exp=18", rise);
    end
    n_tests++;
    if (lock_lost !== 1'b0) begin
      n_fail++; $display("FAIL abort_lost got=%b exp=0", lock_lost);
    end
  endtask

  task automatic test_ratio_change();
    int p[$];
    for (int k = 0; k < 12 && ((cyc - run_start) % 6 != 2); k++) tick();
    div_wr = 1'b1; div_ch = 2'd1; div_val = 8'd3;
    tick();
    div_wr = 1'b0;
    for (int k = 0; k < 24; k++) begin
      tick();
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL ratio_vec cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec());
      end
      if (ce[1] === 1'b1) p.push_back(cyc);
    end
    n_tests++;
    if (p.size() < 3) begin
      n_fail++; $display("FAIL ratio_pulses got=%0d exp>=3", p.size());
    end else begin
      n_tests++;
      if ((p[0] - run_start) % 6 != 5) begin
        n_fail++; $display("FAIL ratio_old_end got=%0d exp=5", (p[0] - run_start) % 6);
      end
      n_tests++;
      if (p[1] - p[0] != 3 || p[2] - p[1] != 3) begin
        n_fail++; $display("FAIL ratio_new_period got=%0d,%0d exp=3,3", p[1] - p[0], p[2] - p[1]);
      end
    end
  endtask

  task automatic test_random_writes();
    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        div_wr  = 1'b1;
        div_ch  = 2'($urandom_range(0, 3));
        div_val = 8'($urandom_range(0, 9));
      end else begin
        div_wr = 1'b0;
      end
      tick();
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL random_vec cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec());
      end
    end
    div_wr = 1'b0;
  endtask

  task automatic test_ratio_one_invalid();
    int highs, npulse;
    div_wr = 1'b1; div_ch = 2'd2; div_val = 8'd1;
    tick();
    div_wr = 1'b0;
    highs = 0;
    for (int k = 0; k < 24; k++) begin
      tick();
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL ratio1_vec cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec());
      end
      if (k >= 12 && ce[2] === 1'b1) highs++;
    end
    n_tests++;
    if (highs != 12) begin
      n_fail++; $display("FAIL ratio_one got=%0d exp=12", highs);
    end
    div_wr_b = 1'b1; div_ch_b = 2'd3; div_val = 8'd2;
    tick();
    div_wr_b = 1'b0;
    npulse = 0;
    for (int k = 0; k < 18; k++) begin
      tick();
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL invalid_vec cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec());
      end
      if (ce_b === 3'b111) npulse++;
    end
    n_tests++;
    if (npulse != 3) begin
      n_fail++; $display("FAIL invalid_ch got=%0d exp=3", npulse);
    end
  endtask

  task automatic test_lock_loss();
    int waited;
    lock_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL loss_vec cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec());
      end
    end
    n_tests++;
    if ({rstn_out, ce, lock_lost} !== 6'b0_0000_1) begin
      n_fail++; $display("FAIL loss_outputs got=%b exp=000001", {rstn_out, ce, lock_lost});
    end
    lost_clr = 1'b1;
    tick();
    lost_clr = 1'b0;
    n_tests++;
    if (lock_lost !== 1'b0) begin
      n_fail++; $display("FAIL lost_clear got=%b exp=0", lock_lost);
    end
    lock_in = 1'b1;
    waited = 0;
    while (locked !== 1'b1 && waited < 40) begin
      tick();
      waited++;
    end
    n_tests++;
    if (locked !== 1'b1) begin
      n_fail++; $display("FAIL loss_relock got=%b exp=1", locked);
    end
    lock_in = 1'b0;
    tick();
    tick();
    lost_clr = 1'b1;
    tick();
    lost_clr = 1'b0;
    n_tests++;
    if ({lock_lost, locked} !== 2'b10) begin
      n_fail++; $display("FAIL set_wins got=%b exp=10", {lock_lost, locked});
    end
    n_tests++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL set_wins_vec got=%b exp=%b", obs_vec(), exp_vec());
    end
  endtask

`ifdef CLK_EN_SYNC_EN
  task automatic test_sync();
    int s, c0, c1, waited;
    sync_in = 1'b1;
    tick();
    sync_in = 1'b0;
    lock_in = 1'b1;
    waited = 0;
    while (locked !== 1'b1 && waited < 40) begin
      tick();
      waited++;
    end
    n_tests++;
    if (locked !== 1'b1) begin
      n_fail++; $display("FAIL sync_relock got=%b exp=1", locked);
    end
    div_wr = 1'b1; div_ch = 2'd0; div_val = 8'd4;
    tick();
    div_ch = 2'd1; div_val = 8'd6;
    tick();
    div_wr = 1'b0;
    for (int k = 0; k < 12 + int'($urandom_range(0, 7)); k++) begin
      tick();
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL presync_vec cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec());
      end
    end
    sync_in = 1'b1;
    tick();
    sync_in = 1'b0;
    s = cyc;
    c0 = -1;
    c1 = -1;
    for (int k = 0; k < 8; k++) begin
      tick();
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL sync_vec cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec());
      end
      if (c0 < 0 && ce[0] === 1'b1) c0 = cyc - s;
      if (c1 < 0 && ce[1] === 1'b1) c1 = cyc - s;
    end
    n_tests++;
    if (c0 != 3 || c1 != 5) begin
      n_fail++; $display("FAIL sync_align got=%0d,%0d exp=3,5", c0, c1);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; lock_in = 1'b0; div_wr = 1'b0; div_ch = '0; div_val = '0;
    lost_clr = 1'b0; div_wr_b = 1'b0; div_ch_b = '0;
`ifdef CLK_EN_SYNC_EN
    sync_in = 1'b0;
`endif
    test_reset();
    test_lock();
    test_reset_mid_run();
    test_settle_abort();
    test_ratio_change();
    test_random_writes();
    test_ratio_one_invalid();
    test_lock_loss();
`ifdef CLK_EN_SYNC_EN
    test_sync();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
